alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
ID/EX issue stage that sits directly upstream of the ALU. It accepts decoded instructions from the decode stage over a valid/ready handshake and resolves register operands through a 3-source forwarding network. It detects load-use hazards and inserts a bubble, then holds operandA/operandB/funct3/funct7 in a registered stage for the ALU and downstream EX logic.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill held and incoming instruction (branch redirect)
id_valid  in  1  decode offers instruction
id_ready  out  1  stage accepts this cycle
id_pc  in  XLEN  instruction PC
id_rs1, id_rs2  in  REG_ADDR_W  source indices
id_uses_rs1, id_uses_rs2  in  1  source actually read
id_rs1_data, id_rs2_data  in  XLEN  register file read data
id_imm  in  XLEN  sign-extended immediate
id_use_imm  in  1  operandB := imm
id_use_pc  in  1  operandA := pc
id_funct3  in  3  ALU funct3
id_funct7  in  1  instr[30]
id_rd  in  REG_ADDR_W  destination
id_reg_write, id_is_load  in  1  writes rd / is a load
alu_result  in  XLEN  ALU result of the held instruction (EX forward)
mem_fwd_valid  in  1  MEM stage writes mem_fwd_rd with valid data
mem_fwd_rd  in  REG_ADDR_W
mem_fwd_data  in  XLEN
wb_fwd_valid  in  1  WB stage writing wb_fwd_rd
wb_fwd_rd  in  REG_ADDR_W
wb_fwd_data  in  XLEN
ex_ready  in  1  downstream consumes held instruction
ex_valid  out  1  held instruction valid
operandA, operandB  out  XLEN  ALU operands
funct3  out  3
funct7  out  1
ex_store_data  out  XLEN  forwarded rs2 value
ex_rd  out  REG_ADDR_W
ex_reg_write, ex_is_load  out  1

Behaviour:
- The clock is clk. Reset rst is synchronous and active-high. On reset, every output register is cleared to 0, so ex_valid=0, operandA=0, operandB=0, funct3=0, funct7=0, ex_store_data=0, ex_rd=0, ex_reg_write=0 and ex_is_load=0.
- id_ready is combinational: id_ready = (!ex_valid | ex_ready) & !hazard & !flush & !rst.
- Transfer in happens when id_valid & id_ready. The instruction is registered, and ex_valid=1 on the next edge (1-cycle latency).
- Transfer out happens when ex_valid & ex_ready. If there is no transfer in on that edge, ex_valid becomes 0.
- When ex_valid & !ex_ready, all outputs hold stable.
- Load-use hazard is asserted when all of the following hold:
  - ex_valid & ex_is_load & ex_rd!=0 & id_valid;
  - and either (id_uses_rs1 & id_rs1==ex_rd) or (id_uses_rs2 & id_rs2==ex_rd).
  - While it holds, id_ready=0.
  - If ex_ready=1, the load leaves and a bubble is created (ex_valid=0).
  - On the next cycle the load data arrives via MEM forwarding.
  - Load-use always costs exactly 1 bubble.
- Forward function fwd(r, rf), evaluated at capture, first match wins:
  1. r==0 gives 0; x0 is never forwarded.
  2. ex_valid & ex_reg_write & !ex_is_load & ex_rd==r gives alu_result.
  3. mem_fwd_valid & mem_fwd_rd==r gives mem_fwd_data.
  4. wb_fwd_valid & wb_fwd_rd==r gives wb_fwd_data.
  5. Otherwise rf.
- Operand and function selection:
  - operandA = id_use_pc ? id_pc : fwd(rs1).
  - operandB = id_use_imm ? id_imm : fwd(rs2).
  - ex_store_data = fwd(rs2).
  - funct7 = (id_use_imm & id_funct3==3'b000) ? 0 : id_funct7, because ADDI has no subtract form.
- Flush is synchronous: next edge gives ex_valid=0. Data fields may keep their old values. Flush overrides a simultaneous transfer in.
- Reset has priority over flush and over any in-flight transfer. An instruction held at reset is dropped.
- No arithmetic is performed here. All widths pass through at XLEN with no truncation.

Decomposition:
- Package riscv_pkg holds:
  - XLEN and REG_ADDR_W;
  - the funct3 localparams (F3_ADD=000, F3_SLL=001, ..., F3_AND=111);
  - an id_ex_t packed struct containing the registered fields.
- One sub-module, operand_fwd_mux, is instantiated twice for rs1 and rs2. It is purely combinational and implements the priority bypass.

Test Plan:
- After reset, drive id_valid=1 with rs1 data 10, rs2 data 20, funct3=000, funct7=0. Next cycle: ex_valid=1, operandA=10, operandB=20; feeding the ALU gives 30.
- Hold the ADD (rd=5) in the stage with alu_result=30, then issue SUB reading x5 (rf value 99), rs2 data 30, funct7=1. Required: operandA=30 (EX forward wins over rf and over MEM=77 on x5), funct7=1.
- Load rd=6 held in the stage, next instruction reads x6. Required: id_ready=0 for 1 cycle, then ex_valid=0 for 1 cycle, then capture with mem_fwd_data=0xDEAD giving operandA=0xDEAD.
- ADDI with id_use_imm=1, imm=-4 (0xFFFFFFFC), funct7=1, rs1 data 4. Required: operandB=0xFFFFFFFC, funct7=0; with rs1=x0 and WB forwarding x0=55, operandA=0.
- ex_ready=0 for 3 cycles with id_valid=1. Required: outputs stable and id_ready=0. Then assert flush together with ex_ready=1. Required: next ex_valid=0 and the new instruction is not captured.
- Assert rst mid-stall. Required: all outputs 0 on the next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the ID/EX issue stage.
//   XLEN, REG_ADDR_W : datapath and register-index widths
//   F3_*             : ALU funct3 encodings
//   id_ex_t          : fields held in the ID/EX register
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned F3_W       = 3;

  localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
  localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
  localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
  localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
  localparam logic [F3_W-1:0] F3_SR   = 3'b101;
  localparam logic [F3_W-1:0] F3_OR   = 3'b110;
  localparam logic [F3_W-1:0] F3_AND  = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    logic [F3_W-1:0]       funct3;
    logic                  funct7;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } id_ex_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority bypass for one source register: x0, EX, MEM, WB, then register file.
//   r, rf            : source index and register-file read data
//   ex_*, alu_result : instruction currently held in EX
//   mem_*, wb_*      : later-stage write-back ports
//   fwd_c            : resolved operand (combinational)
module operand_fwd_mux
  import riscv_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] r,
  input  logic [XLEN-1:0]       rf,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  mem_fwd_valid,
  input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]       mem_fwd_data,
  input  logic                  wb_fwd_valid,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]       wb_fwd_data,
  output logic [XLEN-1:0]       fwd_c
);

  // A load in EX has no data yet; the hazard logic stalls until MEM has it.
  always_comb begin
    fwd_c = rf;
    if (r == '0) begin
      fwd_c = '0;
    end else if (ex_valid && ex_reg_write && !ex_is_load && (ex_rd == r)) begin
      fwd_c = alu_result;
    end else if (mem_fwd_valid && (mem_fwd_rd == r)) begin
      fwd_c = mem_fwd_data;
    end else if (wb_fwd_valid && (wb_fwd_rd == r)) begin
      fwd_c = wb_fwd_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: accepts decoded instructions, resolves operands through
// the bypass network, stalls one cycle on load-use, and holds ALU inputs.
//   id_*            : decoded instruction from decode (valid/ready)
//   alu_result      : EX result of the held instruction (bypass source)
//   mem_fwd_*/wb_*  : later-stage bypass sources
//   ex_*/operand*/funct* : registered instruction toward the ALU (valid/ready)
//   flush           : drops held and incoming instruction
module alu_issue_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic                  id_use_imm,
  input  logic                  id_use_pc,
  input  logic [F3_W-1:0]       id_funct3,
  input  logic                  id_funct7,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  mem_fwd_valid,
  input  logic [REG_ADDR_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]       mem_fwd_data,
  input  logic                  wb_fwd_valid,
  input  logic [REG_ADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]       wb_fwd_data,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       operandA,
  output logic [XLEN-1:0]       operandB,
  output logic [F3_W-1:0]       funct3,
  output logic                  funct7,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_is_load
);

  id_ex_t          q;
  id_ex_t          d_c;
  logic            valid_q;
  logic [XLEN-1:0] rs1_fwd_c;
  logic [XLEN-1:0] rs2_fwd_c;
  logic            hazard_c;
  logic            take_c;

  operand_fwd_mux u_fwd_rs1 (
    .r             (id_rs1),
    .rf            (id_rs1_data),
    .ex_valid      (valid_q),
    .ex_reg_write  (q.reg_write),
    .ex_is_load    (q.is_load),
    .ex_rd         (q.rd),
    .alu_result    (alu_result),
    .mem_fwd_valid (mem_fwd_valid),
    .mem_fwd_rd    (mem_fwd_rd),
    .mem_fwd_data  (mem_fwd_data),
    .wb_fwd_valid  (wb_fwd_valid),
    .wb_fwd_rd     (wb_fwd_rd),
    .wb_fwd_data   (wb_fwd_data),
    .fwd_c         (rs1_fwd_c)
  );

  operand_fwd_mux u_fwd_rs2 (
    .r             (id_rs2),
    .rf            (id_rs2_data),
    .ex_valid      (valid_q),
    .ex_reg_write  (q.reg_write),
    .ex_is_load    (q.is_load),
    .ex_rd         (q.rd),
    .alu_result    (alu_result),
    .mem_fwd_valid (mem_fwd_valid),
    .mem_fwd_rd    (mem_fwd_rd),
    .mem_fwd_data  (mem_fwd_data),
    .wb_fwd_valid  (wb_fwd_valid),
    .wb_fwd_rd     (wb_fwd_rd),
    .wb_fwd_data   (wb_fwd_data),
    .fwd_c         (rs2_fwd_c)
  );

  // Load-use: consumer reads the rd of a load still in EX.
  always_comb begin
    hazard_c = valid_q && q.is_load && (q.rd != '0) && id_valid &&
               ((id_uses_rs1 && (id_rs1 == q.rd)) ||
                (id_uses_rs2 && (id_rs2 == q.rd)));
    id_ready = (!valid_q || ex_ready) && !hazard_c && !flush && !rst;
    take_c   = id_valid && id_ready;
  end

  // Next held contents; ADDI has no subtract form so funct7 is forced low.
  always_comb begin
    d_c            = '0;
    d_c.operand_a  = id_use_pc  ? id_pc  : rs1_fwd_c;
    d_c.operand_b  = id_use_imm ? id_imm : rs2_fwd_c;
    d_c.funct3     = id_funct3;
    d_c.funct7     = (id_use_imm && (id_funct3 == F3_ADD)) ? 1'b0 : id_funct7;
    d_c.store_data = rs2_fwd_c;
    d_c.rd         = id_rd;
    d_c.reg_write  = id_reg_write;
    d_c.is_load    = id_is_load;
  end

  // Stage register: reset beats flush beats capture; data kept on drain/flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (take_c) begin
      valid_q <= 1'b1;
      q       <= d_c;
    end else if (valid_q && ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_comb begin
    ex_valid      = valid_q;
    operandA      = q.operand_a;
    operandB      = q.operand_b;
    funct3        = q.funct3;
    funct7        = q.funct7;
    ex_store_data = q.store_data;
    ex_rd         = q.rd;
    ex_reg_write  = q.reg_write;
    ex_is_load    = q.is_load;
  end

endmodule
